// File: rtl/fifo_uart_tx_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_drain
//   Read-side consumer of an async FIFO, running in the UART TX clock domain.
//   It pops one word whenever the FIFO is non-empty and transmission is
//   enabled, then serialises it as start / data (LSB first) / optional parity /
//   stop. It sends one bit per i_CLK cycle. Frames run back-to-back while
//   words remain, because the next pop is taken during the stop-bit cycle.
//
// Ports
//   i_CLK           UART TX clock (same clock as the FIFO read side)
//   i_RST           asynchronous active-high reset
//   i_FIFO_EMPTY    FIFO empty flag (read domain)
//   i_FIFO_RD_DATA  FIFO head word, valid while i_FIFO_EMPTY = 0
//   o_FIFO_R_INC    pop strobe, high for exactly the pop cycle
//   i_TX_EN         1 = allow new frames to start
//   i_PAR_EN        1 = append a parity bit (sampled at pop)
//   i_PAR_TYP       0 = even parity, 1 = odd parity (sampled at pop)
//   o_TX_OUT        serial line, idles high
//   o_BUSY          high while a frame is on the line
//   o_FRAME_DONE    high during the stop-bit cycle
// -----------------------------------------------------------------------------
module fifo_uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] i_FIFO_RD_DATA,
  output logic                  o_FIFO_R_INC,
  input  logic                  i_TX_EN,
  input  logic                  i_PAR_EN,
  input  logic                  i_PAR_TYP,
  output logic                  o_TX_OUT,
  output logic                  o_BUSY,
  output logic                  o_FRAME_DONE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  // Parity of a word; odd_typ inverts it so the frame carries odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic odd_typ);
    return (^data) ^ odd_typ;
  endfunction

  state_t                state_q,   state_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q,  par_en_d;
  logic                  pop_s;
  logic                  tx_s;

  // Pop decision. It is only legal in IDLE or in the stop cycle. Gating with
  // i_RST keeps the strobe low while reset is held, so that no word is lost.
  always_comb begin
    pop_s = i_TX_EN & ~i_FIFO_EMPTY & ~i_RST &
            ((state_q == IDLE) | (state_q == STOP));
  end

  // Next-state and datapath load logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    if (pop_s) begin
      // Frame settings are captured here and held for the whole frame.
      shift_d   = i_FIFO_RD_DATA;
      par_bit_d = parity_bit(i_FIFO_RD_DATA, i_PAR_TYP);
      par_en_d  = i_PAR_EN;
      state_d   = START;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        START: begin
          state_d   = DATA;
          bit_cnt_d = {CNT_WIDTH{1'b0}};
        end
        DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
          end
        end
        PARITY: begin
          state_d = STOP;
        end
        STOP: begin
          // A pop here would already have been handled above.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      shift_q   <= {DATA_WIDTH{1'b0}};
      bit_cnt_q <= {CNT_WIDTH{1'b0}};
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
    end
  end

  // Line decode from registered state only, with no path from the inputs.
  always_comb begin
    tx_s = 1'b1;
    case (state_q)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_q[bit_cnt_q];
      PARITY:  tx_s = par_bit_q;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  assign o_TX_OUT     = tx_s;
  assign o_BUSY       = (state_q != IDLE);
  assign o_FRAME_DONE = (state_q == STOP);
  assign o_FIFO_R_INC = pop_s;

endmodule
